prim_executor: RTL and testbench
================================

# prim_executor

Parametrised action-primitive executor for the match-action stage. On `start_i` it fetches a chain of 64-bit primitives from SRAM at `prog_addr_i` and executes each one against the packet buffer at `pkt_base_i`. It supports NOP/end, checksum, add, copy-field, set-field and set-port. It owns a single SRAM port, which it muxes between its own FSM and an internal checksum engine, and it reports completion or error to the pipeline controller.

## Interface
- `ADDR_W`, 32: SRAM byte-address width.
- `PORT_W`, 8: egress port width.
- `MAX_PRIMS`, 16: maximum primitives per program. Exceeding it raises an error.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  level; run the program. It must stay high until `done_o` is seen.
- `prog_addr_i`  in  ADDR_W  byte address of the first primitive (4-aligned).
- `pkt_base_i`  in  ADDR_W  packet buffer base; all field offsets are relative to it.
- `mem_ce_o`, `mem_we_o`  out  1  SRAM enable and write.
- `mem_addr_o`  out  ADDR_W  byte address.
- `mem_width_o`  out  4  access width in bytes (1, 2 or 4); 0 when idle.
- `mem_wdata_o`  out  32  write data, right-aligned.
- `mem_rdata_i`  in  32  read data, right-aligned, valid the cycle after a read is presented.
- `egress_port_o`  out  PORT_W  last port set by SET_PORT.
- `port_valid_o`  out  1  SET_PORT executed in this run.
- `done_o`  out  1  program finished; held until `start_i` is low.
- `err_o`  out  1  run aborted; valid while `done_o` is high.
- `prim_count_o`  out  8  number of primitives executed, the terminating one included.

## Operation
- Primitive format:
  - [63:58] opcode.
  - [57:48] dst offset.
  - [47:38] src offset.
  - [37:32] len in bytes.
  - [31:0] imm.
  - The first word (at pc) is bits [63:32]; the word at pc+4 is bits [31:0].
- States: IDLE, FETCH_HI, FETCH_LO, DECODE, RD, WR, CKSUM, DONE.
- Fetch sequence:
  - IDLE moves to FETCH_HI on `start_i`, latching pc, base and clearing counters/port.
  - FETCH_HI presents a read at pc.
  - FETCH_LO presents a read at pc+4 and captures the high word.
  - DECODE captures the low word, sets pc += 8 and increments prim_count.
- Opcodes:
  - 0 NOP: go to DONE with `err_o`=0.
  - 1 CKSUM: pulse the engine start, then wait in CKSUM for `ready`. The engine ones-complement-sums len bytes (len even, 2..62) at base+src and writes the 16-bit complement at base+dst. Then FETCH_HI.
  - 2 ADD: RD presents a read of len bytes at base+dst. WR writes (rdata + imm) mod 2^(8·len).
  - 3 COPY_FIELD: RD presents a read of len bytes at base+src. WR writes that data to base+dst.
  - 4 SET_FIELD: WR writes imm truncated to len bytes at base+dst.
  - 5 SET_PORT: `egress_port_o` <= imm[PORT_W-1:0]; `port_valid_o` <= 1; then FETCH_HI.
- Errors: each of the following goes to DONE with `err_o`=1.
  - Any other opcode.
  - len ∉ {1,2,4} for opcodes 2–4.
  - Odd len or len=0 for CKSUM.
  - prim_count reaching MAX_PRIMS without a NOP.
- Address arithmetic is mod 2^ADDR_W (wraps silently).
- SRAM mux:
  - Outputs are combinational from state and registers.
  - In CKSUM the engine drives the SRAM port; otherwise the FSM does.
  - IDLE and DONE drive `ce`=0 and `width`=0.
- DONE: when `start_i` falls, return to IDLE and clear `done_o`/`err_o`. `egress_port_o` and `port_valid_o` hold until the next start.

## Timing
- Reset values: every output is 0; state is IDLE; the checksum engine is idle. A reset mid-run aborts immediately: `mem_ce_o`=0 from the cycle after the reset edge, and no partial write completes.
- Cycles per primitive, from FETCH_HI to the next FETCH_HI or DONE:
  - NOP: 3.
  - SET_PORT: 3.
  - SET_FIELD: 4.
  - ADD / COPY_FIELD: 5.
  - CKSUM: 3 + engine latency. The engine uses len/2 reads, 1 write and a 1-cycle ready pulse.
- A single-NOP program has `done_o` high 4 cycles after `start_i` is first sampled high.
- `start_i` is ignored outside IDLE and DONE. If `start_i` stays high in DONE, the block stays in DONE and does not restart.

## Structure
- Shared package `def.v` holds:
  - Opcode constants.
  - State encodings.
  - Primitive field bit positions.
  - Mux select constants.
- Sub-module `cksum_unit`:
  - Ports: start/ready handshake, src/len/dst inputs, and its own SRAM port.
  - Reads 16-bit words, folds carries, writes `~sum` as a 2-byte write.
- The mux and the FSM stay in `prim_executor`.

## Test plan
- Program [SET_FIELD dst=0 len=2 imm=0x1234; NOP]: a 2-byte write of 0x1234 at base+0; `done_o`=1, `err_o`=0, `prim_count_o`=2.
- ADD dst=4 len=1 imm=0x05 on a byte of 0xFE: writes 0x03 (wrap); total 5 cycles from fetch to next fetch.
- COPY_FIELD src=8 dst=12 len=4 followed by SET_PORT imm=0x1A3: dst holds the src word; `egress_port_o`=0xA3; `port_valid_o`=1.
- CKSUM src=14 len=20 dst=24 over a known IPv4 header: 0xB1E6 is written at base+24, then the next primitive executes.
- Opcode 0x3F, or ADD with len=3: DONE with `err_o`=1; no write issued.
- A 16-primitive program without a NOP gives `err_o`=1 and `prim_count_o`=16. Asserting `rst` mid-ADD gives `mem_ce_o`=0 next cycle and all outputs 0.

Source files
------------

// File: rtl/prim_executor_pkg.sv
// Shared definitions for the action-primitive executor: opcodes, FSM encodings,
// primitive field positions, SRAM mux selects and small arithmetic helpers.
package prim_executor_pkg;

  localparam logic [5:0] OP_NOP       = 6'd0;
  localparam logic [5:0] OP_CKSUM     = 6'd1;
  localparam logic [5:0] OP_ADD       = 6'd2;
  localparam logic [5:0] OP_COPY      = 6'd3;
  localparam logic [5:0] OP_SET_FIELD = 6'd4;
  localparam logic [5:0] OP_SET_PORT  = 6'd5;

  // Bit positions inside the 64-bit primitive {word@pc, word@pc+4}
  localparam int OPC_HI = 63;
  localparam int OPC_LO = 58;
  localparam int DST_HI = 57;
  localparam int DST_LO = 48;
  localparam int SRC_HI = 47;
  localparam int SRC_LO = 38;
  localparam int LEN_HI = 37;
  localparam int LEN_LO = 32;
  localparam int IMM_HI = 31;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_HI,
    ST_FETCH_LO,
    ST_DECODE,
    ST_RD,
    ST_WR,
    ST_CKSUM,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    CK_IDLE,
    CK_RD,
    CK_WR,
    CK_RDY
  } cks_state_e;

  typedef enum logic {
    MUX_FSM,
    MUX_CKS
  } mux_sel_e;

  // Ones-complement 16-bit add with end-around carry
  function automatic logic [15:0] add_fold(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  function automatic logic [31:0] len_mask(input logic [5:0] len);
    case (len)
      6'd1:    return 32'h0000_00FF;
      6'd2:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/prim_executor_cksum_unit.sv
// Internet checksum engine: sums len bytes as 16-bit words starting at src and
// writes the complemented folded sum as a 2-byte store at dst, then pulses ready.
module prim_executor_cksum_unit
  import prim_executor_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [5:0]        len_i,
  output logic              ready_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_width_o,
  output logic [15:0]       mem_wdata_o,
  input  logic [15:0]       mem_rdata_i
);

  cks_state_e        st_q, st_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [4:0]        left_q, left_d;
  logic [15:0]       sum_q, sum_d;
  logic              acc_q, acc_d;
  logic [15:0]       sum_next;

  // Read data lands one cycle after each read, so accumulation lags by one
  assign sum_next = add_fold(sum_q, mem_rdata_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= CK_IDLE;
      addr_q <= '0;
      dst_q  <= '0;
      left_q <= '0;
      sum_q  <= '0;
      acc_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      addr_q <= addr_d;
      dst_q  <= dst_d;
      left_q <= left_d;
      sum_q  <= sum_d;
      acc_q  <= acc_d;
    end
  end

  always_comb begin
    st_d        = st_q;
    addr_d      = addr_q;
    dst_d       = dst_q;
    left_d      = left_q;
    sum_d       = sum_q;
    acc_d       = acc_q;
    ready_o     = 1'b0;
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_width_o = 4'd0;
    mem_wdata_o = '0;
    case (st_q)
      CK_IDLE: begin
        if (start_i) begin
          addr_d = src_addr_i;
          dst_d  = dst_addr_i;
          left_d = 5'(({1'b0, len_i} + 7'd1) >> 1);
          sum_d  = '0;
          acc_d  = 1'b0;
          st_d   = CK_RD;
        end
      end
      CK_RD: begin
        mem_ce_o    = 1'b1;
        mem_addr_o  = addr_q;
        mem_width_o = 4'd2;
        addr_d      = addr_q + ADDR_W'(2);
        left_d      = left_q - 5'd1;
        acc_d       = 1'b1;
        if (acc_q) sum_d = sum_next;
        if (left_q == 5'd1) st_d = CK_WR;
      end
      CK_WR: begin
        mem_ce_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = dst_q;
        mem_width_o = 4'd2;
        mem_wdata_o = ~sum_next;
        acc_d       = 1'b0;
        st_d        = CK_RDY;
      end
      default: begin
        ready_o = 1'b1;
        st_d    = CK_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/prim_executor.sv
// Action-primitive executor: fetches 64-bit primitives from SRAM, runs them
// against the packet buffer and shares its single SRAM port with the checksum engine.
module prim_executor
  import prim_executor_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int PORT_W    = 8,
  parameter int MAX_PRIMS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [ADDR_W-1:0] pkt_base_i,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_width_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic [PORT_W-1:0] egress_port_o,
  output logic              port_valid_o,
  output logic              done_o,
  output logic              err_o,
  output logic [7:0]        prim_count_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, base_q, base_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [PORT_W-1:0] port_q, port_d;
  logic              pv_q, pv_d, err_q, err_d;

  logic [63:0]       prim;
  logic [5:0]        opcode, len;
  logic [9:0]        dst_off, src_off;
  logic [ADDR_W-1:0] dst_addr, src_addr;
  logic [7:0]        cnt_inc;
  logic              rw_op, len_ok_rw, cks_len_ok, prim_bad;

  logic              cks_start, cks_ready;
  logic              cks_ce, cks_we;
  logic [ADDR_W-1:0] cks_addr;
  logic [3:0]        cks_width;
  logic [15:0]       cks_wdata;

  logic              f_ce, f_we;
  logic [ADDR_W-1:0] f_addr;
  logic [3:0]        f_width;
  logic [31:0]       f_wdata;
  mux_sel_e          mux_sel;

  assign prim     = {hi_q, lo_q};
  assign opcode   = prim[OPC_HI:OPC_LO];
  assign dst_off  = prim[DST_HI:DST_LO];
  assign src_off  = prim[SRC_HI:SRC_LO];
  assign len      = prim[LEN_HI:LEN_LO];
  assign dst_addr = base_q + ADDR_W'(dst_off);
  assign src_addr = base_q + ADDR_W'(src_off);
  assign cnt_inc  = cnt_q + 8'd1;

  assign rw_op      = (opcode == OP_ADD) || (opcode == OP_COPY) || (opcode == OP_SET_FIELD);
  assign len_ok_rw  = (len == 6'd1) || (len == 6'd2) || (len == 6'd4);
  assign cks_len_ok = (len != 6'd0) && !len[0];
  assign prim_bad   = (opcode > OP_SET_PORT) ||
                      (rw_op && !len_ok_rw) ||
                      ((opcode == OP_CKSUM) && !cks_len_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      base_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      port_q  <= '0;
      pv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      base_q  <= base_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      port_q  <= port_d;
      pv_q    <= pv_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    base_d    = base_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    port_d    = port_q;
    pv_d      = pv_q;
    err_d     = err_q;
    cks_start = 1'b0;
    f_ce      = 1'b0;
    f_we      = 1'b0;
    f_addr    = '0;
    f_width   = 4'd0;
    f_wdata   = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          pc_d    = prog_addr_i;
          base_d  = pkt_base_i;
          cnt_d   = '0;
          port_d  = '0;
          pv_d    = 1'b0;
          err_d   = 1'b0;
          state_d = ST_FETCH_HI;
        end
      end
      ST_FETCH_HI: begin
        f_ce    = 1'b1;
        f_addr  = pc_q;
        f_width = 4'd4;
        state_d = ST_FETCH_LO;
      end
      ST_FETCH_LO: begin
        f_ce    = 1'b1;
        f_addr  = pc_q + ADDR_W'(4);
        f_width = 4'd4;
        hi_d    = mem_rdata_i;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        // Opcode/len come from hi_q; only imm needs the word arriving now
        lo_d  = mem_rdata_i;
        pc_d  = pc_q + ADDR_W'(8);
        cnt_d = cnt_inc;
        if (prim_bad) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (opcode == OP_NOP) begin
          state_d = ST_DONE;
        end else if (cnt_inc == 8'(MAX_PRIMS)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          case (opcode)
            OP_CKSUM: begin
              cks_start = 1'b1;
              state_d   = ST_CKSUM;
            end
            OP_ADD, OP_COPY: state_d = ST_RD;
            OP_SET_FIELD:    state_d = ST_WR;
            default: begin
              port_d  = mem_rdata_i[PORT_W-1:0];
              pv_d    = 1'b1;
              state_d = ST_FETCH_HI;
            end
          endcase
        end
      end
      ST_RD: begin
        f_ce    = 1'b1;
        f_addr  = (opcode == OP_ADD) ? dst_addr : src_addr;
        f_width = 4'(len);
        state_d = ST_WR;
      end
      ST_WR: begin
        f_ce    = 1'b1;
        f_we    = 1'b1;
        f_addr  = dst_addr;
        f_width = 4'(len);
        case (opcode)
          OP_ADD:  f_wdata = (mem_rdata_i + lo_q) & len_mask(len);
          OP_COPY: f_wdata = mem_rdata_i & len_mask(len);
          default: f_wdata = lo_q & len_mask(len);
        endcase
        state_d = ST_FETCH_HI;
      end
      ST_CKSUM: begin
        if (cks_ready) state_d = ST_FETCH_HI;
      end
      default: begin
        if (!start_i) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  prim_executor_cksum_unit #(
    .ADDR_W(ADDR_W)
  ) u_cksum (
    .clk        (clk),
    .rst        (rst),
    .start_i    (cks_start),
    .src_addr_i (src_addr),
    .dst_addr_i (dst_addr),
    .len_i      (len),
    .ready_o    (cks_ready),
    .mem_ce_o   (cks_ce),
    .mem_we_o   (cks_we),
    .mem_addr_o (cks_addr),
    .mem_width_o(cks_width),
    .mem_wdata_o(cks_wdata),
    .mem_rdata_i(mem_rdata_i[15:0])
  );

  assign mux_sel = (state_q == ST_CKSUM) ? MUX_CKS : MUX_FSM;

  always_comb begin
    if (mux_sel == MUX_CKS) begin
      mem_ce_o    = cks_ce;
      mem_we_o    = cks_we;
      mem_addr_o  = cks_addr;
      mem_width_o = cks_width;
      mem_wdata_o = {16'd0, cks_wdata};
    end else begin
      mem_ce_o    = f_ce;
      mem_we_o    = f_we;
      mem_addr_o  = f_addr;
      mem_width_o = f_width;
      mem_wdata_o = f_wdata;
    end
  end

  assign egress_port_o = port_q;
  assign port_valid_o  = pv_q;
  assign done_o        = (state_q == ST_DONE);
  assign err_o         = err_q;
  assign prim_count_o  = cnt_q;

endmodule

// File: tb/tb_prim_executor.sv
// Scoreboard bench for prim_executor: big-endian byte SRAM model, expected
// writes queued per program and matched as the DUT issues them.
module tb_prim_executor;

  localparam int          ADDR_W    = 32;
  localparam int          PORT_W    = 8;
  localparam int          MAX_PRIMS = 16;
  localparam logic [31:0] BASE      = 32'h0000_0400;

  localparam logic [5:0] T_NOP   = 6'd0;
  localparam logic [5:0] T_CKSUM = 6'd1;
  localparam logic [5:0] T_ADD   = 6'd2;
  localparam logic [5:0] T_COPY  = 6'd3;
  localparam logic [5:0] T_SET   = 6'd4;
  localparam logic [5:0] T_PORT  = 6'd5;

  logic              clk;
  logic              rst;
  logic              start_i;
  logic [ADDR_W-1:0] prog_addr_i;
  logic [ADDR_W-1:0] pkt_base_i;
  logic              mem_ce_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [3:0]        mem_width_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;
  logic [PORT_W-1:0] egress_port_o;
  logic              port_valid_o;
  logic              done_o;
  logic              err_o;
  logic [7:0]        prim_count_o;

  logic [7:0]  mem [0:4095];
  logic [63:0] exp_wr_q [$];
  logic [63:0] wr_obs;
  int          n_cmp;
  int          n_bad;

  prim_executor #(
    .ADDR_W   (ADDR_W),
    .PORT_W   (PORT_W),
    .MAX_PRIMS(MAX_PRIMS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .prog_addr_i  (prog_addr_i),
    .pkt_base_i   (pkt_base_i),
    .mem_ce_o     (mem_ce_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_width_o  (mem_width_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .egress_port_o(egress_port_o),
    .port_valid_o (port_valid_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .prim_count_o (prim_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] wr_key(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    return {a[27:0], w, d};
  endfunction

  function automatic logic [31:0] rd_mem(input logic [11:0] a, input logic [3:0] w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < int'(w); i++) r = (r << 8) | 32'(mem[(int'(a) + i) & 4095]);
    return r;
  endfunction

  // Big-endian byte SRAM, read data registered
  always @(posedge clk) begin
    if (mem_ce_o) begin
      if (mem_we_o) begin
        for (int i = 0; i < int'(mem_width_o); i++)
          mem[(int'(mem_addr_o[11:0]) + i) & 4095] = 8'(mem_wdata_o >> (8 * (int'(mem_width_o) - 1 - i)));
      end else begin
        mem_rdata_i <= rd_mem(mem_addr_o[11:0], mem_width_o);
      end
    end
  end

  always @(negedge clk) begin
    if (mem_ce_o && mem_we_o) begin
      wr_obs = wr_key(mem_addr_o, mem_width_o, mem_wdata_o);
      $display("wr addr=%h width=%0d data=%h", mem_addr_o, mem_width_o, mem_wdata_o);
      if (exp_wr_q.size() == 0) check_val("wr_unexpected", wr_obs, '1);
      else check_val("wr", wr_obs, exp_wr_q.pop_front());
    end
  end

  task automatic put_prim(input int a, input logic [5:0] op, input logic [9:0] dst,
                          input logic [9:0] src, input logic [5:0] len, input logic [31:0] imm);
    logic [63:0] p;
    p = {op, dst, src, len, imm};
    for (int i = 0; i < 8; i++) mem[(a + i) & 4095] = p[63 - 8 * i -: 8];
  endtask

  task automatic put_bytes(input int a, input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) mem[(a + i) & 4095] = v[8 * (n - 1 - i) +: 8];
  endtask

  task automatic run_prog(input string tag, input int pa, input int exp_cnt, input bit exp_err, input int exp_cyc);
    int n;
    n = 0;
    @(negedge clk);
    prog_addr_i = pa;
    pkt_base_i  = BASE;
    start_i     = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done_o && n < 400);
    check_val({tag, "_done"}, 64'(done_o), 64'd1);
    check_val({tag, "_cycles"}, 64'(n), 64'(exp_cyc));
    check_val({tag, "_err"}, 64'(err_o), 64'(exp_err));
    check_val({tag, "_count"}, 64'(prim_count_o), 64'(exp_cnt));
    repeat (3) @(posedge clk);
    #1;
    check_val({tag, "_hold"}, {55'd0, done_o, prim_count_o}, {55'd0, 1'b1, 8'(exp_cnt)});
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check_val({tag, "_release"}, {62'd0, done_o, err_o}, 64'd0);
    check_val({tag, "_wr_left"}, 64'(exp_wr_q.size()), 64'd0);
    exp_wr_q.delete();
    $display("run %s: cycles=%0d err=%0b count=%0d", tag, n, exp_err, exp_cnt);
  endtask

  initial begin
    logic [159:0] hdr;
    n_cmp       = 0;
    n_bad       = 0;
    rst         = 1'b1;
    start_i     = 1'b0;
    prog_addr_i = '0;
    pkt_base_i  = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'd0;

    put_prim('h000, T_SET,   10'd0,  10'd0,  6'd2,  32'h0000_1234);
    put_prim('h008, T_NOP,   10'd0,  10'd0,  6'd0,  32'd0);
    put_prim('h040, T_ADD,   10'd4,  10'd0,  6'd1,  32'h0000_0005);
    put_prim('h048, T_NOP,   10'd0,  10'd0,  6'd0,  32'd0);
    put_prim('h080, T_COPY,  10'd12, 10'd8,  6'd4,  32'd0);
    put_prim('h088, T_PORT,  10'd0,  10'd0,  6'd0,  32'h0000_01A3);
    put_prim('h090, T_NOP,   10'd0,  10'd0,  6'd0,  32'd0);
    put_prim('h0C0, T_CKSUM, 10'd24, 10'd14, 6'd20, 32'd0);
    put_prim('h0C8, T_SET,   10'd40, 10'd0,  6'd1,  32'h0000_0077);
    put_prim('h0D0, T_NOP,   10'd0,  10'd0,  6'd0,  32'd0);
    put_prim('h100, 6'h3F,   10'd0,  10'd0,  6'd2,  32'h0000_BEEF);
    put_prim('h140, T_ADD,   10'd4,  10'd0,  6'd3,  32'h0000_0001);
    put_prim('h180, T_CKSUM, 10'd24, 10'd14, 6'd3,  32'd0);
    put_prim('h1C0, T_NOP,   10'd0,  10'd0,  6'd0,  32'd0);
    for (int i = 0; i < 16; i++) put_prim('h200 + 8 * i, T_PORT, 10'd0, 10'd0, 6'd0, 32'(i + 1));
    put_prim('h280, T_ADD,   10'd4,  10'd0,  6'd1,  32'h0000_0005);
    put_bytes(BASE + 4, 32'hFE, 1);
    put_bytes(BASE + 8, 32'hDEAD_BEEF, 4);

    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outs", {39'd0, done_o, err_o, mem_ce_o, mem_we_o, mem_width_o,
                             port_valid_o, egress_port_o, prim_count_o}, 64'd0);
    check_val("reset_bus", {mem_addr_o, mem_wdata_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    exp_wr_q.push_back(wr_key(BASE, 4'd2, 32'h0000_1234));
    run_prog("set_field", 'h000, 2, 1'b0, 1 + 4 + 3);

    exp_wr_q.push_back(wr_key(BASE + 4, 4'd1, (32'hFE + 32'h05) & 32'hFF));
    run_prog("add_wrap", 'h040, 2, 1'b0, 1 + 5 + 3);

    exp_wr_q.push_back(wr_key(BASE + 12, 4'd4, 32'hDEAD_BEEF));
    run_prog("copy_port", 'h080, 3, 1'b0, 1 + 5 + 3 + 3);
    check_val("port_hold", {55'd0, port_valid_o, egress_port_o}, {55'd0, 1'b1, 8'hA3});

    hdr = 160'h4500_003c_1c46_4000_4006_0000_ac10_0a63_ac10_0a0c;
    for (int i = 0; i < 20; i++) mem[(int'(BASE) + 14 + i) & 4095] = hdr[159 - 8 * i -: 8];
    exp_wr_q.push_back(wr_key(BASE + 24, 4'd2, 32'h0000_B1E6));
    exp_wr_q.push_back(wr_key(BASE + 40, 4'd1, 32'h0000_0077));
    run_prog("cksum", 'h0C0, 3, 1'b0, 1 + (3 + 10 + 2) + 4 + 3);
    check_val("port_cleared", 64'(port_valid_o), 64'd0);

    run_prog("bad_opcode", 'h100, 1, 1'b1, 1 + 3);
    run_prog("add_len3", 'h140, 1, 1'b1, 1 + 3);
    run_prog("cksum_odd", 'h180, 1, 1'b1, 1 + 3);
    run_prog("single_nop", 'h1C0, 1, 1'b0, 4);
    run_prog("max_prims", 'h200, MAX_PRIMS, 1'b1, 1 + 3 * MAX_PRIMS);

    // Reset while an ADD is presenting its read; its write must never appear
    @(negedge clk);
    prog_addr_i = 'h280;
    start_i     = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_val("rst_mid_rd", {58'd0, mem_ce_o, mem_we_o, mem_width_o}, {58'd0, 1'b1, 1'b0, 4'd1});
    @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check_val("rst_mid_ce", 64'(mem_ce_o), 64'd0);
    check_val("rst_mid_outs", {39'd0, done_o, err_o, mem_ce_o, mem_we_o, mem_width_o,
                               port_valid_o, egress_port_o, prim_count_o}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_idle_ce", 64'(mem_ce_o), 64'd0);
    check_val("final_wr_left", 64'(exp_wr_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
